// File: rtl/odu_pkg.sv
// Shared definitions for the ODU row/frame builder: state encoding, field helpers
// and the parameter legality check used at elaboration.
package odu_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OH      = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

    localparam int MAX_FIELD_W = 1024;

    function automatic int fill_width(input int k);
        return $clog2(2 * k + 1);
    endfunction

    function automatic bit params_ok(input int data_w, input int oh_w,
                                     input int rows, input int row_words);
        return (oh_w > 0) && (oh_w % 8 == 0) && (oh_w <= MAX_FIELD_W) &&
               (data_w % oh_w == 0) && (data_w / oh_w >= 2) &&
               (rows >= 1) && (rows <= 15) && (row_words >= 3);
    endfunction

    // Row r is tagged with the nibble r+1 in both halves of every header byte.
    function automatic logic [7:0] hdr_byte(input logic [3:0] row);
        logic [3:0] n;
        n = row + 4'd1;
        return {n, n};
    endfunction

    function automatic logic [MAX_FIELD_W-1:0] stuff_field(input int width,
                                                           input logic [7:0] fill_byte);
        logic [MAX_FIELD_W-1:0] f;
        f = '0;
        for (int i = 0; i < MAX_FIELD_W / 8; i++) begin
            if (i * 8 < width) f[i*8 +: 8] = fill_byte;
        end
        return f;
    endfunction

endpackage

// File: rtl/odu_frame_builder_gearbox.sv
// Chunk gearbox: a 2K-chunk shift buffer (oldest chunk at the MSB end) that appends
// whole input beats and releases K or K-1 chunks per output word.
module odu_chunk_gearbox
    import odu_pkg::*;
#(
    parameter int DATA_W = 384,
    parameter int OH_W   = 128
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [DATA_W-1:0]                     s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic                                  pop,
    input  logic                                  pop_full,
    output logic [DATA_W-1:0]                     head,
    output logic [fill_width(DATA_W/OH_W)-1:0]    fill
);
    localparam int K      = DATA_W / OH_W;
    localparam int FILL_W = fill_width(K);
    localparam int BUF_W  = 2 * DATA_W;

    logic [BUF_W-1:0]  shreg_q, shreg_next;
    logic [FILL_W-1:0] fill_q, fill_next, pop_n, remain;
    logic              accept;
    int                pop_bits, remain_bits;

    assign s_ready = enable && !rst && (fill_q <= FILL_W'(K));
    assign accept  = s_ready && s_valid;
    assign head    = shreg_q[BUF_W-1 -: DATA_W];
    assign fill    = fill_q;

    // Bits past the fill level are kept zero, so a new beat can simply be OR-ed in.
    always_comb begin
        pop_n = '0;
        if (pop) pop_n = pop_full ? FILL_W'(K) : FILL_W'(K - 1);
        remain      = fill_q - pop_n;
        pop_bits    = int'(pop_n) * OH_W;
        remain_bits = int'(remain) * OH_W;
        shreg_next  = shreg_q << pop_bits;
        fill_next   = remain;
        if (accept) begin
            shreg_next = shreg_next | ({s_data, {DATA_W{1'b0}}} >> remain_bits);
            fill_next  = remain + FILL_W'(K);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else begin
            shreg_q <= shreg_next;
            fill_q  <= fill_next;
        end
    end

endmodule

// File: rtl/odu_frame_builder.sv
// ODU row/frame builder: overhead word, payload words and a stuffed end word per row,
// with frame/row sync and a free-running MFAS, fed from a valid/ready payload stream.
module odu_frame_builder
    import odu_pkg::*;
#(
    parameter int         DATA_W     = 384,
    parameter int         OH_W       = 128,
    parameter int         ROWS       = 3,
    parameter int         ROW_WORDS  = 80,
    parameter logic [7:0] STUFF_BYTE = 8'h99
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [DATA_W-1:0] o_odu_data_out,
    output logic              o_odu_valid_out,
    output logic              o_odu_fs_out,
    output logic              o_odu_rs_out,
    output logic [7:0]        o_odu_mfas_out
);
    localparam int K      = DATA_W / OH_W;
    localparam int FILL_W = fill_width(K);
    localparam int WCNT_W = $clog2(ROW_WORDS);
    localparam logic [WCNT_W-1:0]      LAST_PAYLOAD = WCNT_W'(ROW_WORDS - 2);
    localparam logic [3:0]             LAST_ROW     = 4'(ROWS - 1);
    localparam logic [MAX_FIELD_W-1:0] STUFF_ALL    = stuff_field(OH_W, STUFF_BYTE);

    if (!params_ok(DATA_W, OH_W, ROWS, ROW_WORDS)) begin : g_bad_params
        $error("odu_frame_builder: illegal parameter set");
    end

    logic [1:0]        state;
    logic [WCNT_W-1:0] word_cnt;
    logic [3:0]        row_cnt;
    logic [7:0]        mfas;
    logic [FILL_W-1:0] fill, need;
    logic [DATA_W-1:0] head, word;
    logic              need_full, fire;

    assign need_full = (state == ST_PAYLOAD);
    assign need      = need_full ? FILL_W'(K) : FILL_W'(K - 1);
    assign fire      = i_enable && (state != ST_IDLE) && (fill >= need);

    odu_chunk_gearbox #(.DATA_W(DATA_W), .OH_W(OH_W)) u_gb (
        .clk      (i_clk),
        .rst      (i_rst),
        .enable   (i_enable),
        .s_data   (i_s_data),
        .s_valid  (i_s_valid),
        .s_ready  (o_s_ready),
        .pop      (fire),
        .pop_full (need_full),
        .head     (head),
        .fill     (fill)
    );

    always_comb begin
        word = head;
        case (state)
            ST_OH:   word = {{(OH_W/8){hdr_byte(row_cnt)}}, head[DATA_W-1 -: DATA_W-OH_W]};
            ST_END:  word = {head[DATA_W-1 -: DATA_W-OH_W], STUFF_ALL[OH_W-1:0]};
            default: word = head;
        endcase
    end

    // Counters only move on fire, so starvation and enable-low both freeze the row position.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            row_cnt  <= '0;
            mfas     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_enable) state <= ST_OH;
                ST_OH: if (fire) begin
                    state    <= ST_PAYLOAD;
                    word_cnt <= WCNT_W'(1);
                end
                ST_PAYLOAD: if (fire) begin
                    if (word_cnt == LAST_PAYLOAD) state <= ST_END;
                    word_cnt <= word_cnt + 1'b1;
                end
                ST_END: if (fire) begin
                    state    <= ST_OH;
                    word_cnt <= '0;
                    if (row_cnt == LAST_ROW) begin
                        row_cnt <= '0;
                        mfas    <= mfas + 8'd1;
                    end else begin
                        row_cnt <= row_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_odu_data_out  <= '0;
            o_odu_valid_out <= 1'b0;
            o_odu_fs_out    <= 1'b0;
            o_odu_rs_out    <= 1'b0;
            o_odu_mfas_out  <= '0;
        end else begin
            o_odu_valid_out <= fire;
            o_odu_rs_out    <= fire && (state == ST_OH);
            o_odu_fs_out    <= fire && (state == ST_OH) && (row_cnt == 4'd0);
            if (fire) begin
                o_odu_data_out <= word;
                o_odu_mfas_out <= mfas;
            end
        end
    end

endmodule

// File: tb/tb_odu_frame_builder.sv
// Bench for odu_frame_builder: a small configuration for directed row/frame checks and
// the default configuration at full rate, both scored against a chunk-queue model.
module tb_odu_frame_builder;
    localparam int S_W = 32,  S_OHW = 8,   S_ROWS = 3, S_RW = 80 / 20, S_K = 4;
    localparam int L_W = 384, L_OHW = 128, L_ROWS = 3, L_RW = 80,      L_K = 3;

    typedef struct packed {
        logic [S_W-1:0] d;
        logic           fs;
        logic           rs;
        logic [7:0]     mf;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // small configuration
    logic           rst_s = 1'b1, en_s = 1'b0, valid_s = 1'b0;
    logic [S_W-1:0] data_s = 32'h00010203;
    logic           ready_s, vout_s, fs_s, rs_s;
    logic [S_W-1:0] dout_s;
    logic [7:0]     mf_s;

    // default configuration
    logic           rst_l = 1'b1, en_l = 1'b0, valid_l = 1'b0;
    logic [L_W-1:0] data_l = '0;
    logic           ready_l, vout_l, fs_l, rs_l;
    logic [L_W-1:0] dout_l;
    logic [7:0]     mf_l;

    odu_frame_builder #(.DATA_W(S_W), .OH_W(S_OHW), .ROWS(S_ROWS), .ROW_WORDS(S_RW),
                        .STUFF_BYTE(8'h99)) dut_s (
        .i_clk(clk), .i_rst(rst_s), .i_enable(en_s), .i_s_data(data_s),
        .i_s_valid(valid_s), .o_s_ready(ready_s), .o_odu_data_out(dout_s),
        .o_odu_valid_out(vout_s), .o_odu_fs_out(fs_s), .o_odu_rs_out(rs_s),
        .o_odu_mfas_out(mf_s)
    );

    odu_frame_builder #(.DATA_W(L_W), .OH_W(L_OHW), .ROWS(L_ROWS), .ROW_WORDS(L_RW),
                        .STUFF_BYTE(8'h99)) dut_l (
        .i_clk(clk), .i_rst(rst_l), .i_enable(en_l), .i_s_data(data_l),
        .i_s_valid(valid_l), .o_s_ready(ready_l), .o_odu_data_out(dout_l),
        .o_odu_valid_out(vout_l), .o_odu_fs_out(fs_l), .o_odu_rs_out(rs_l),
        .o_odu_mfas_out(mf_l)
    );

    function automatic logic [7:0] hdr_model(input int row);
        return 8'((row + 1) * 17);
    endfunction

    // ---------------- reference model: accepted chunks in order, word position by count
    logic [S_OHW-1:0] exp_q_s[$];
    logic [L_OHW-1:0] exp_q_l[$];
    obs_t             log_s[$];
    obs_t             last_s;
    int               n_s = 0, n_l = 0;
    logic             adv_s = 1'b0, adv_l = 1'b0;
    logic [7:0]       next_byte_s = 8'h04;

    int               pos_s, row_s, mfe_s, need_s;
    logic [S_W-1:0]   e_s;
    logic [S_OHW-1:0] c_s;
    obs_t             got_s, want_s;

    always @(negedge clk) begin
        if (vout_s === 1'b1) begin
            pos_s  = n_s % S_RW;
            row_s  = (n_s / S_RW) % S_ROWS;
            mfe_s  = (n_s / (S_RW * S_ROWS)) % 256;
            need_s = (pos_s == 0 || pos_s == S_RW - 1) ? S_K - 1 : S_K;
            got_s  = {dout_s, fs_s, rs_s, mf_s};
            total++;
            if (exp_q_s.size() < need_s) begin
                bad++;
                $display("FAIL small_underflow word=%0d got=%h queued=%0d required>=%0d",
                         n_s, dout_s, exp_q_s.size(), need_s);
            end else begin
                e_s = '0;
                for (int i = 0; i < S_K; i++) begin
                    if (pos_s == 0 && i == 0) c_s = {(S_OHW/8){hdr_model(row_s)}};
                    else if (pos_s == S_RW - 1 && i == S_K - 1) c_s = {(S_OHW/8){8'h99}};
                    else c_s = exp_q_s.pop_front();
                    e_s = {e_s[S_W-S_OHW-1:0], c_s};
                end
                want_s = {e_s, (pos_s == 0 && row_s == 0), (pos_s == 0), 8'(mfe_s)};
                last_s = want_s;
                if (got_s !== want_s)
                    begin
                        bad++;
                        $display("FAIL small_word n=%0d got d=%h fs=%b rs=%b mf=%h required d=%h fs=%b rs=%b mf=%h",
                                 n_s, got_s.d, got_s.fs, got_s.rs, got_s.mf,
                                 want_s.d, want_s.fs, want_s.rs, want_s.mf);
                    end
            end
            if (log_s.size() < 16) log_s.push_back(got_s);
            n_s++;
        end
        total++;
        if (exp_q_s.size() > 2 * S_K) begin
            bad++;
            $display("FAIL small_fill got=%0d required<=%0d", exp_q_s.size(), 2 * S_K);
        end
        if (rst_s) begin
            exp_q_s.delete();
            log_s.delete();
            n_s = 0;
        end else if (valid_s && ready_s) begin
            for (int i = 0; i < S_K; i++) exp_q_s.push_back(data_s[S_W-1-i*S_OHW -: S_OHW]);
            adv_s = 1'b1;
        end
    end

    int               pos_l, row_l, mfe_l, need_l;
    logic [L_W-1:0]   e_l;
    logic [L_OHW-1:0] c_l;
    logic [L_W+9:0]   got_l, want_l;

    always @(negedge clk) begin
        if (vout_l === 1'b1) begin
            pos_l  = n_l % L_RW;
            row_l  = (n_l / L_RW) % L_ROWS;
            mfe_l  = (n_l / (L_RW * L_ROWS)) % 256;
            need_l = (pos_l == 0 || pos_l == L_RW - 1) ? L_K - 1 : L_K;
            got_l  = {dout_l, fs_l, rs_l, mf_l};
            total++;
            if (exp_q_l.size() < need_l) begin
                bad++;
                $display("FAIL wide_underflow word=%0d queued=%0d required>=%0d",
                         n_l, exp_q_l.size(), need_l);
            end else begin
                e_l = '0;
                for (int i = 0; i < L_K; i++) begin
                    if (pos_l == 0 && i == 0) c_l = {(L_OHW/8){hdr_model(row_l)}};
                    else if (pos_l == L_RW - 1 && i == L_K - 1) c_l = {(L_OHW/8){8'h99}};
                    else c_l = exp_q_l.pop_front();
                    e_l = {e_l[L_W-L_OHW-1:0], c_l};
                end
                want_l = {e_l, (pos_l == 0 && row_l == 0), (pos_l == 0), 8'(mfe_l)};
                if (got_l !== want_l) begin
                    bad++;
                    $display("FAIL wide_word n=%0d got=%h required=%h", n_l, got_l, want_l);
                end
            end
            n_l++;
        end
        total++;
        if (exp_q_l.size() > 2 * L_K) begin
            bad++;
            $display("FAIL wide_fill got=%0d required<=%0d", exp_q_l.size(), 2 * L_K);
        end
        if (rst_l) begin
            exp_q_l.delete();
            n_l = 0;
        end else if (valid_l && ready_l) begin
            for (int i = 0; i < L_K; i++) exp_q_l.push_back(data_l[L_W-1-i*L_OHW -: L_OHW]);
            adv_l = 1'b1;
        end
    end

    // ---------------- sources: advance the beat after it has been accepted
    initial begin
        for (int i = 0; i < L_W / 32; i++) data_l[i*32 +: 32] = $urandom;
        forever begin
            @(posedge clk);
            #1;
            if (adv_s) begin
                adv_s  = 1'b0;
                data_s = {next_byte_s, next_byte_s + 8'd1, next_byte_s + 8'd2, next_byte_s + 8'd3};
                next_byte_s = next_byte_s + 8'd4;
            end
            if (adv_l) begin
                adv_l = 1'b0;
                for (int i = 0; i < L_W / 32; i++) data_l[i*32 +: 32] = $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pos_s(input int pos, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            settle();
            if (n_s % S_RW == pos && vout_s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst_s = 1'b1; rst_l = 1'b1; en_s = 1'b0; en_l = 1'b0; valid_s = 1'b0; valid_l = 1'b0;
        repeat (3) tick();
        settle();
        total++;
        if ({dout_s, vout_s, fs_s, rs_s, mf_s, ready_s} !== '0) begin
            bad++;
            $display("FAIL reset_small got=%h/%b%b%b/%h/%b required all zero",
                     dout_s, vout_s, fs_s, rs_s, mf_s, ready_s);
        end
        total++;
        if ({dout_l, vout_l, fs_l, rs_l, mf_l, ready_l} !== '0) begin
            bad++;
            $display("FAIL reset_wide got v=%b fs=%b rs=%b mf=%h rdy=%b required all zero",
                     vout_l, fs_l, rs_l, mf_l, ready_l);
        end
        en_s = 1'b1;
        valid_s = 1'b1;
        #1;
        total++;
        if (ready_s !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b required=0", ready_s);
        end
    endtask

    task automatic test_rows();
        int   idx[7];
        obs_t ref_tab[7];
        idx     = '{0, 1, 2, 3, 4, 8, 12};
        ref_tab = '{{32'h11000102, 1'b1, 1'b1, 8'h00}, {32'h03040506, 1'b0, 1'b0, 8'h00},
                    {32'h0708090A, 1'b0, 1'b0, 8'h00}, {32'h0B0C0D99, 1'b0, 1'b0, 8'h00},
                    {32'h220E0F10, 1'b0, 1'b1, 8'h00}, {32'h331C1D1E, 1'b0, 1'b1, 8'h00},
                    {32'h112A2B2C, 1'b1, 1'b1, 8'h01}};
        tick();
        rst_s = 1'b0;
        rst_l = 1'b0;
        for (int c = 0; c < 200 && log_s.size() < 13; c++) settle();
        total++;
        if (log_s.size() < 13) begin
            bad++;
            $display("FAIL rows_timeout got=%0d words required=13", log_s.size());
            return;
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (log_s[idx[i]] !== ref_tab[i]) begin
                bad++;
                $display("FAIL rows_word%0d got=%h required=%h", idx[i], log_s[idx[i]], ref_tab[i]);
            end
        end
    endtask

    task automatic test_starve();
        bit ok, gap;
        int n0;
        wait_pos_s(1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL starve_sync got=timeout required=payload word");
            return;
        end
        tick();
        valid_s = 1'b0;
        gap = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            if (vout_s === 1'b0) gap = 1'b1;
            tick();
        end
        valid_s = 1'b1;
        total++;
        if (!gap) begin
            bad++;
            $display("FAIL starve_gap got=no gap required=valid_out gap");
        end
        n0 = n_s;
        repeat (12) settle();
        total++;
        if (n_s - n0 < 4) begin
            bad++;
            $display("FAIL starve_resume got=%0d words required>=4", n_s - n0);
        end
    endtask

    task automatic test_enable();
        bit ok;
        wait_pos_s(0, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL enable_sync got=timeout required=row start");
            return;
        end
        tick();
        en_s = 1'b0;
        settle();
        total++;
        if (ready_s !== 1'b0) begin
            bad++;
            $display("FAIL enable_ready got=%b required=0", ready_s);
        end
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if ({vout_s, fs_s, rs_s, dout_s, mf_s} !== {3'b000, last_s.d, last_s.mf}) begin
                bad++;
                $display("FAIL enable_hold%0d got v=%b d=%h mf=%h required v=0 d=%h mf=%h",
                         c, vout_s, dout_s, mf_s, last_s.d, last_s.mf);
            end
        end
        en_s = 1'b1;
    endtask

    task automatic test_mfas_wrap();
        bit found;
        int rs_cnt;
        found = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            settle();
            if (vout_s && fs_s && mf_s == 8'hFF) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mfas_ff got=timeout required=frame with mfas FF");
            return;
        end
        found = 1'b0;
        rs_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            settle();
            if (vout_s && fs_s) begin
                found = 1'b1;
                break;
            end
            if (vout_s && rs_s) rs_cnt++;
        end
        total++;
        if (!found || mf_s !== 8'h00) begin
            bad++;
            $display("FAIL mfas_wrap got found=%b mf=%h required mf=00", found, mf_s);
        end
        total++;
        if (rs_cnt != S_ROWS - 1) begin
            bad++;
            $display("FAIL fs_align got=%0d rows required=%0d", rs_cnt, S_ROWS - 1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_pos_s(1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_sync got=timeout required=payload word");
            return;
        end
        tick();
        rst_s = 1'b1;
        settle();
        settle();
        total++;
        if ({dout_s, vout_s, fs_s, rs_s, mf_s, ready_s} !== '0) begin
            bad++;
            $display("FAIL rstmid_zero got=%h/%b%b%b/%h/%b required all zero",
                     dout_s, vout_s, fs_s, rs_s, mf_s, ready_s);
        end
        tick();
        rst_s = 1'b0;
        for (int c = 0; c < 50 && log_s.size() < 1; c++) settle();
        total++;
        if (log_s.size() < 1) begin
            bad++;
            $display("FAIL rstmid_first got=timeout required=one word");
        end else if ({log_s[0].d[31:24], log_s[0].fs, log_s[0].rs, log_s[0].mf} !== {8'h11, 2'b11, 8'h00}) begin
            bad++;
            $display("FAIL rstmid_first got=%h required=11xxxxxx fs=1 rs=1 mf=00", log_s[0]);
        end
    endtask

    task automatic test_random();
        int n0;
        n0 = n_s;
        for (int c = 0; c < 400; c++) begin
            tick();
            valid_s = ($urandom_range(0, 99) < 70);
            en_s    = ($urandom_range(0, 99) < 90);
        end
        tick();
        valid_s = 1'b1;
        en_s    = 1'b1;
        repeat (10) settle();
        total++;
        if (n_s <= n0) begin
            bad++;
            $display("FAIL random_progress got=%0d words required>0", n_s - n0);
        end
    endtask

    task automatic test_full_rate();
        tick();
        en_l    = 1'b1;
        valid_l = 1'b1;
        for (int c = 0; c < 3000 && n_l < 2 * L_ROWS * L_RW; c++) settle();
        total++;
        if (n_l < 2 * L_ROWS * L_RW) begin
            bad++;
            $display("FAIL wide_frames got=%0d words required=%0d", n_l, 2 * L_ROWS * L_RW);
        end
    endtask

    initial begin
        test_reset();
        test_rows();
        test_starve();
        test_enable();
        test_mfas_wrap();
        test_reset_mid();
        test_random();
        test_full_rate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
